// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcode encodings and FSM states.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_slice.sv
// Purely combinational 1-bit ALU slice: add/sub/AND/OR selected by {S2,S1}.
module alu_slice (
    input  logic A,
    input  logic B,
    input  logic CarryIn,
    input  logic S1,
    input  logic S2,
    output logic ResAlu,
    output logic CarrySum,
    output logic Borrow
);

    logic sum_bit;

    // The sum and the difference share the same XOR; only the carry/borrow terms differ.
    assign sum_bit  = A ^ B ^ CarryIn;
    assign CarrySum = (A & B) | (A & CarryIn) | (B & CarryIn);
    assign Borrow   = (~A & B) | (~A & CarryIn) | (B & CarryIn);

    always_comb begin
        ResAlu = 1'b0;
        case ({S2, S1})
            2'b00:   ResAlu = sum_bit;
            2'b01:   ResAlu = sum_bit;
            2'b10:   ResAlu = A & B;
            2'b11:   ResAlu = A | B;
            default: ResAlu = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams operands LSB-first through one alu_slice.
// Optional Zero result flag enabled by defining ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic [1:0]       Op,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    output logic             Zero,
`endif
    output logic             CarryOut
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] opa_q,    opa_d;
    logic [WIDTH-1:0] opb_q,    opb_d;
    logic [1:0]       op_q,     op_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] result_q, result_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             zero_q,   zero_d;
`endif

    logic res_bit;
    logic slice_carry;
    logic slice_borrow;

    alu_slice u_slice (
        .A        (opa_q[0]),
        .B        (opb_q[0]),
        .CarryIn  (carry_q),
        .S1       (op_q[0]),
        .S2       (op_q[1]),
        .ResAlu   (res_bit),
        .CarrySum (slice_carry),
        .Borrow   (slice_borrow)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        result_d = result_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    opa_d   = OpA;
                    opb_d   = OpB;
                    op_d    = Op;
                    cnt_d   = '0;
                    carry_d = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    zero_d  = 1'b1;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                opa_d = opa_q >> 1;
                opb_d = opb_q >> 1;
                // Result fills from the MSB so bit 0 lands in place after WIDTH shifts.
                result_d = (result_q >> 1) | (WIDTH'(res_bit) << (WIDTH - 1));
                case (op_q)
                    OP_ADD:  carry_d = slice_carry;
                    OP_SUB:  carry_d = slice_borrow;
                    default: carry_d = 1'b0;
                endcase
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                if (res_bit) begin
                    zero_d = 1'b0;
                end
`endif
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= OP_ADD;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Result   = result_q;
    assign CarryOut = carry_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign Zero     = zero_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=8); Zero is checked when
// ALU_SERIAL_ZERO_FLAG_EN is defined.
module tb_alu_serial_seq;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             RstN;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [1:0]       Op;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             CarryOut;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             Zero;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .RstN     (RstN),
        .InValid  (InValid),
        .InReady  (InReady),
        .OpA      (OpA),
        .OpB      (OpB),
        .Op       (Op),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        .Zero     (Zero),
`endif
        .CarryOut (CarryOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one operation, check latency and result, then hand the result off.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                         input logic [7:0] exp_r, input logic exp_c, input logic exp_z,
                         input string tag);
        int cyc;
        chk({tag, "_inready"}, InReady, 1'b1);
        OpA = a; OpB = b; Op = op; InValid = 1'b1;
        step();
        InValid = 1'b0;
        // Scramble inputs: the block must work from its latched copies.
        OpA = ~a; OpB = ~b; Op = ~op;
        cyc = 0;
        while (!OutValid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, WIDTH);
        chk({tag, "_result"}, Result, exp_r);
        chk({tag, "_carry"}, CarryOut, exp_c);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        chk({tag, "_zero"}, Zero, exp_z);
`else
        if (exp_z === 1'bx) $display("unreachable");
`endif
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk({tag, "_idle_inready"}, InReady, 1'b1);
        chk({tag, "_idle_outvalid"}, OutValid, 1'b0);
        $display("op %s: A=%02h B=%02h op=%0d -> Result=%02h CarryOut=%0b (latency %0d)",
                 tag, a, b, op, Result, CarryOut, cyc);
    endtask

    initial begin
        int cyc;
        int n_res;
        int t_res [2];
        logic [7:0] r_res [2];
        logic       c_res [2];

        RstN = 1'b0; InValid = 1'b0; OpA = '0; OpB = '0; Op = 2'b00; OutReady = 1'b0;
        step();
        chk("rst_inready", InReady, 1'b1);
        chk("rst_outvalid", OutValid, 1'b0);
        chk("rst_result", Result, 8'h00);
        chk("rst_carry", CarryOut, 1'b0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        chk("rst_zero", Zero, 1'b1);
`endif
        RstN = 1'b1;
        step();

        do_op(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, "add_ff_01");
        do_op(8'h05, 8'h07, 2'b01, 8'hFE, 1'b1, 1'b0, "sub_05_07");
        do_op(8'h07, 8'h05, 2'b01, 8'h02, 1'b0, 1'b0, "sub_07_05");
        do_op(8'hF0, 8'h3C, 2'b10, 8'h30, 1'b0, 1'b0, "and_f0_3c");
        do_op(8'hF0, 8'h0F, 2'b11, 8'hFF, 1'b0, 1'b0, "or_f0_0f");
        do_op(8'h0F, 8'hF0, 2'b10, 8'h00, 1'b0, 1'b1, "and_zero");

        // Backpressure: result must hold while OutReady is low; new requests ignored.
        OpA = 8'h30; OpB = 8'h0C; Op = 2'b00; InValid = 1'b1;
        step();
        InValid = 1'b0;
        cyc = 0;
        while (!OutValid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("bp_latency", cyc, WIDTH);
        for (int i = 0; i < 5; i++) begin
            OpA = 8'h11 * i[7:0]; OpB = 8'h01; Op = 2'b11; InValid = 1'b1;
            step();
            chk("bp_outvalid", OutValid, 1'b1);
            chk("bp_inready", InReady, 1'b0);
            chk("bp_result", Result, 8'h3C);
            chk("bp_carry", CarryOut, 1'b0);
            $display("backpressure cycle %0d: OutValid=%0b InReady=%0b Result=%02h",
                     i, OutValid, InReady, Result);
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk("bp_release_inready", InReady, 1'b1);
        chk("bp_release_outvalid", OutValid, 1'b0);
        step();
        chk("bp_no_capture", InReady, 1'b1);

        // Asynchronous reset in the middle of RUN.
        OpA = 8'hAA; OpB = 8'h55; Op = 2'b00; InValid = 1'b1;
        step();
        InValid = 1'b0;
        step();
        step();
        step();
        RstN = 1'b0;
        #1;
        chk("midrst_outvalid", OutValid, 1'b0);
        chk("midrst_inready", InReady, 1'b1);
        chk("midrst_result", Result, 8'h00);
        chk("midrst_carry", CarryOut, 1'b0);
        $display("mid-run reset: OutValid=%0b InReady=%0b Result=%02h", OutValid, InReady, Result);
        #2;
        RstN = 1'b1;
        step();
        do_op(8'h12, 8'h34, 2'b00, 8'h46, 1'b0, 1'b0, "add_12_34");

        // Back-to-back with OutReady tied high.
        OutReady = 1'b1;
        OpA = 8'hFF; OpB = 8'h01; Op = 2'b00; InValid = 1'b1;
        step();
        OpA = 8'h12; OpB = 8'h01; Op = 2'b00;
        n_res = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (i == 10) InValid = 1'b0;
            if (OutValid && n_res < 2) begin
                t_res[n_res] = i;
                r_res[n_res] = Result;
                c_res[n_res] = CarryOut;
                $display("b2b result %0d at cycle %0d: Result=%02h CarryOut=%0b",
                         n_res, i, Result, CarryOut);
                n_res++;
            end
        end
        OutReady = 1'b0;
        chk("b2b_count", n_res, 2);
        if (n_res == 2) begin
            chk("b2b_t0", t_res[0], 8);
            chk("b2b_t1", t_res[1], 18);
            chk("b2b_r0", r_res[0], 8'h00);
            chk("b2b_c0", c_res[0], 1'b1);
            chk("b2b_r1", r_res[1], 8'h13);
            chk("b2b_c1", c_res[1], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
